// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-interface types and arbiter definitions for the icache/dcache memory port.
// The MEM_ARB_STARVE_EN build option is consumed by mem_port_arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 64;
  localparam int TAG_W   = 4;

  typedef logic [ADDR_W-1:0]  ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [TAG_W-1:0]   MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } MEM_OWNER_ENTRY;

  localparam int MEM_ARB_STARVE_LIMIT = 8;

endpackage

// File: rtl/mem_port_arbiter_tag_owner_table.sv
// Per-tag owner table: remembers which cache issued each outstanding load.
// Tag 0 is never allocated; a same-cycle allocation overrides the response clear.
module mem_tag_owner_table
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc_en_i,
  input  MEM_TAG   alloc_tag_i,
  input  MEM_OWNER alloc_owner_i,
  input  MEM_TAG   rsp_tag_i,
  output logic     rsp_valid_o,
  output MEM_OWNER rsp_owner_o
);

  MEM_OWNER_ENTRY table_q [NUM_TAGS];
  MEM_OWNER_ENTRY table_d [NUM_TAGS];
  MEM_OWNER_ENTRY rsp_entry;

  // Response lookup against the registered table (old owner on a same-tag collision)
  always_comb begin
    rsp_entry   = table_q[rsp_tag_i];
    rsp_valid_o = (rsp_tag_i != {TAG_W{1'b0}}) && rsp_entry.valid;
    rsp_owner_o = rsp_entry.owner;
  end

  // Next-state table: allocation has precedence over the response clear
  always_comb begin
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (alloc_en_i && (t != 0) && (alloc_tag_i == TAG_W'(t))) begin
        table_d[t] = '{valid: 1'b1, owner: alloc_owner_i};
      end else if (rsp_valid_o && (rsp_tag_i == TAG_W'(t))) begin
        table_d[t] = '{valid: 1'b0, owner: table_q[t].owner};
      end else begin
        table_d[t] = table_q[t];
      end
    end
  end

  // Table register with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        table_q[t] <= '{valid: 1'b0, owner: OWNER_I};
      end
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between icache and dcache and routes responses by tag.
// Define MEM_ARB_STARVE_EN to add the icache anti-starvation counter.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  MEM_COMMAND icache_command,
  input  ADDR        icache_addr,
  input  MEM_COMMAND dcache_command,
  input  ADDR        dcache_addr,
  input  MEM_BLOCK   dcache_data,
  input  MEM_TAG     mem2proc_transaction_tag,
  input  MEM_BLOCK   mem2proc_data,
  input  MEM_TAG     mem2proc_data_tag,
  output MEM_COMMAND proc2mem_command,
  output ADDR        proc2mem_addr,
  output MEM_BLOCK   proc2mem_data,
  output MEM_TAG     icache_transaction_tag,
  output MEM_TAG     dcache_transaction_tag,
  output MEM_TAG     icache_data_tag,
  output MEM_TAG     dcache_data_tag,
  output MEM_BLOCK   icache_data,
  output MEM_BLOCK   dcache_data_out,
  output logic       dcache_request
);

  logic       icache_req;
  logic       dcache_req;
  logic       starve_force;
  logic       grant_i;
  logic       grant_d;
  logic       alloc_en;
  MEM_TAG     rsp_tag;
  logic       rsp_valid;
  MEM_OWNER   rsp_owner;

  // Requests are ignored during reset so nothing is issued or allocated
  always_comb begin
    icache_req = !reset && (icache_command != MEM_NONE);
    dcache_req = !reset && (dcache_command != MEM_NONE);
    grant_d    = dcache_req && !starve_force;
    grant_i    = icache_req && !grant_d;
  end

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  // A rejected icache grant holds the count so the icache keeps priority
  always_comb begin
    starve_force = icache_req && (starve_cnt_q == LIMIT);
    if (!icache_req) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (grant_i) begin
      starve_cnt_d = (mem2proc_transaction_tag != {TAG_W{1'b0}}) ? {CNT_W{1'b0}} : starve_cnt_q;
    end else if (starve_cnt_q == LIMIT) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Starvation counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_starve_limit;

  assign starve_force        = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // Memory command bus and accept-tag steering to the granted side
  always_comb begin
    proc2mem_command       = MEM_NONE;
    proc2mem_addr          = {ADDR_W{1'b0}};
    proc2mem_data          = {BLOCK_W{1'b0}};
    icache_transaction_tag = {TAG_W{1'b0}};
    dcache_transaction_tag = {TAG_W{1'b0}};
    if (grant_d) begin
      proc2mem_command       = dcache_command;
      proc2mem_addr          = dcache_addr;
      proc2mem_data          = (dcache_command == MEM_STORE) ? dcache_data : {BLOCK_W{1'b0}};
      dcache_transaction_tag = mem2proc_transaction_tag;
    end else if (grant_i) begin
      proc2mem_command       = icache_command;
      proc2mem_addr          = icache_addr;
      icache_transaction_tag = mem2proc_transaction_tag;
    end else begin
      proc2mem_command = MEM_NONE;
    end
    dcache_request = grant_d;
    alloc_en       = (proc2mem_command == MEM_LOAD) && (mem2proc_transaction_tag != {TAG_W{1'b0}});
  end

  assign rsp_tag = reset ? {TAG_W{1'b0}} : mem2proc_data_tag;

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_table (
    .clock         (clock),
    .reset         (reset),
    .alloc_en_i    (alloc_en),
    .alloc_tag_i   (mem2proc_transaction_tag),
    .alloc_owner_i (grant_d ? OWNER_D : OWNER_I),
    .rsp_tag_i     (rsp_tag),
    .rsp_valid_o   (rsp_valid),
    .rsp_owner_o   (rsp_owner)
  );

  // Response routing to the recorded owner; data is broadcast outside reset
  always_comb begin
    icache_data_tag = (rsp_valid && (rsp_owner == OWNER_I)) ? rsp_tag : {TAG_W{1'b0}};
    dcache_data_tag = (rsp_valid && (rsp_owner == OWNER_D)) ? rsp_tag : {TAG_W{1'b0}};
    icache_data     = reset ? {BLOCK_W{1'b0}} : mem2proc_data;
    dcache_data_out = reset ? {BLOCK_W{1'b0}} : mem2proc_data;
  end

endmodule
